// File: rtl/sersub_pkg.sv
// sersub_pkg: mode codes and FSM state encoding shared by the serial subtractor
// Exports: MODE_SUB (A-B), MODE_ONES (~A), MODE_TWOS (-A), MODE_RSUB (B-A), state_t {ST_IDLE, ST_RUN}
package sersub_pkg;
    localparam logic [1:0] MODE_SUB  = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_TWOS = 2'b10;
    localparam logic [1:0] MODE_RSUB = 2'b11;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational cell computing x - y - bin
// Ports: x_i, y_i, bin_i (in) -> d_o difference bit, bout_o borrow out
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    always_comb begin
        d_o    = x_i ^ y_i ^ bin_i;
        bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
    end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B / B-A / ~A / -A engine, LSB first, one bit per clock
// Ports: clk, rst_n (async active-low), start, mode[1:0], a/b[WIDTH-1:0] in;
//        busy, done (1-cycle pulse), result[WIDTH-1:0], borrow_out, overflow out
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic [1:0]       mode_q;
    logic             bin_q, busy_q, done_q, bo_q, ov_q;
    logic             x, y, d, bout, last;

    // Ones/twos complement are 1...1 - A and 0 - A through the same cell
    always_comb begin
        x     = (mode_q == MODE_SUB)  ? a_q[cnt_q] :
                (mode_q == MODE_ONES) ? 1'b1 :
                (mode_q == MODE_TWOS) ? 1'b0 : b_q[cnt_q];
        y     = (mode_q == MODE_SUB) ? b_q[cnt_q] : a_q[cnt_q];
        last  = (cnt_q == CW'(WIDTH - 1));
        res_d = {d, res_q[WIDTH-1:1]};
        cnt_d = last ? cnt_q : cnt_q + CW'(1);
    end

    full_subtractor u_fs (
        .x_i   (x),
        .y_i   (y),
        .bin_i (bin_q),
        .d_o   (d),
        .bout_o(bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_SUB;
            res_q   <= '0;
            bin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            done_q <= 1'b0;
            if (start) begin
                a_q     <= a;
                b_q     <= b;
                mode_q  <= mode;
                bin_q   <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_RUN;
            end
        end else begin
            res_q <= res_d;
            bin_q <= bout;
            cnt_q <= cnt_d;
            if (last) begin
                bo_q    <= bout;
                ov_q    <= (x != y) && (d != x);
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = res_q;
    assign borrow_out = bo_q;
    assign overflow   = ov_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH 8, 2 and 32
module tb_serial_subtractor;
    import sersub_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        bo;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 0, busy8, done8, bo8, ov8;
    logic [1:0]  mode8 = 0;
    logic [7:0]  a8 = 0, b8 = 0, res8;
    logic        start2 = 0, busy2, done2, bo2, ov2;
    logic [1:0]  mode2 = 0;
    logic [1:0]  a2 = 0, b2 = 0, res2;
    logic        start32 = 0, busy32, done32, bo32, ov32;
    logic [1:0]  mode32 = 0;
    logic [31:0] a32 = 0, b32 = 0, res32;

    exp_t sb8[$], sb2[$], sb32[$];
    int pass_cnt = 0, total_cnt = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8), .borrow_out(bo8), .overflow(ov8));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .result(res2), .borrow_out(bo2), .overflow(ov2));
    serial_subtractor #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .start(start32), .mode(mode32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32), .borrow_out(bo32), .overflow(ov32));

    function automatic exp_t model(int w, logic [1:0] m, logic [31:0] a, logic [31:0] b);
        exp_t e;
        logic [31:0] mask, x, y;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x = (m == MODE_SUB) ? a : (m == MODE_ONES) ? mask : (m == MODE_TWOS) ? 32'd0 : b;
        y = (m == MODE_SUB) ? b : a;
        x = x & mask;
        y = y & mask;
        e.r  = (x - y) & mask;
        e.bo = x < y;
        e.ov = (x[w-1] != y[w-1]) && (e.r[w-1] != x[w-1]);
        return e;
    endfunction

    task automatic issue8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1; mode8 = m; a8 = a; b8 = b;
        sb8.push_back(model(8, m, {24'd0, a}, {24'd0, b}));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int n, output int g, output bit to);
        n = 0; g = 0;
        while (!done8 && g < 200) begin
            if (busy8) n++;
            g++;
            @(negedge clk);
        end
        to = !done8;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy8, done8, res8, bo8, ov8} !== 12'd0)
            $display("FAIL reset_state got %b exp 0", {busy8, done8, res8, bo8, ov8});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes;
        logic [17:0] tbl [6] = '{{MODE_SUB, 8'h35, 8'h12}, {MODE_SUB, 8'h12, 8'h35}, {MODE_RSUB, 8'h12, 8'h35},
                                 {MODE_ONES, 8'hA5, 8'h00}, {MODE_TWOS, 8'h80, 8'h00}, {MODE_TWOS, 8'h00, 8'h77}};
        int n, g;
        bit to;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue8(tbl[i][17:16], tbl[i][15:8], tbl[i][7:0]);
            wait_done8(n, g, to);
            e = sb8.pop_front();
            total_cnt++;
            if (to) $display("FAIL modes[%0d] timeout waiting for done", i);
            else pass_cnt++;
            total_cnt++;
            if (n !== 8) $display("FAIL modes[%0d] busy_cycles got %0d exp 8", i, n);
            else pass_cnt++;
            total_cnt++;
            if ({res8, bo8, ov8} !== {e.r[7:0], e.bo, e.ov})
                $display("FAIL modes[%0d] res/bo/ov got %h/%b/%b exp %h/%b/%b", i, res8, bo8, ov8, e.r[7:0], e.bo, e.ov);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (done8 !== 1'b0) $display("FAIL modes[%0d] done_width got %b exp 0", i, done8);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy;
        int n, g;
        bit to;
        exp_t e;
        issue8(MODE_SUB, 8'h35, 8'h12);
        repeat (2) @(negedge clk);
        start8 = 1'b1; mode8 = MODE_TWOS; a8 = 8'hFF; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n, g, to);
        e = sb8.pop_front();
        total_cnt++;
        if (to || {res8, bo8, ov8} !== {e.r[7:0], e.bo, e.ov})
            $display("FAIL busy_start to=%b got %h/%b/%b exp %h/%b/%b", to, res8, bo8, ov8, e.r[7:0], e.bo, e.ov);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n, g;
        bit to;
        exp_t e;
        issue8(MODE_SUB, 8'h7F, 8'hFF);
        wait_done8(n, g, to);
        e = sb8.pop_front();
        total_cnt++;
        if (to || {res8, bo8, ov8} !== {e.r[7:0], e.bo, e.ov})
            $display("FAIL b2b_first to=%b got %h/%b/%b exp %h/%b/%b", to, res8, bo8, ov8, e.r[7:0], e.bo, e.ov);
        else pass_cnt++;
        issue8(MODE_RSUB, 8'h12, 8'h35);
        total_cnt++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) $display("FAIL b2b_accept done=%b busy=%b exp 0/1", done8, busy8);
        else pass_cnt++;
        wait_done8(n, g, to);
        e = sb8.pop_front();
        total_cnt++;
        if (to || g !== 8) $display("FAIL b2b_latency got %0d cycles exp 8", g);
        else pass_cnt++;
        total_cnt++;
        if ({res8, bo8, ov8} !== {e.r[7:0], e.bo, e.ov})
            $display("FAIL b2b_second got %h/%b/%b exp %h/%b/%b", res8, bo8, ov8, e.r[7:0], e.bo, e.ov);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int n, g;
        bit to;
        exp_t e;
        issue8(MODE_SUB, 8'h00, 8'h01);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy8, done8, res8, bo8, ov8} !== 12'd0)
            $display("FAIL reset_mid_run got %b exp 0", {busy8, done8, res8, bo8, ov8});
        else pass_cnt++;
        sb8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue8(MODE_SUB, 8'hC3, 8'h4D);
        wait_done8(n, g, to);
        e = sb8.pop_front();
        total_cnt++;
        if (to || n !== 8 || {res8, bo8, ov8} !== {e.r[7:0], e.bo, e.ov})
            $display("FAIL after_reset to=%b busy=%0d got %h/%b/%b exp %h/%b/%b", to, n, res8, bo8, ov8, e.r[7:0], e.bo, e.ov);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random_w2;
        int n, g;
        exp_t e;
        for (int i = 0; i < 1000; i++) begin
            start2 = 1'b1; mode2 = 2'($urandom_range(0, 3)); a2 = 2'($urandom); b2 = 2'($urandom);
            sb2.push_back(model(2, mode2, {30'd0, a2}, {30'd0, b2}));
            @(negedge clk);
            start2 = 1'b0; mode2 = 2'($urandom); a2 = 2'($urandom); b2 = 2'($urandom);
            n = 0; g = 0;
            while (!done2 && g < 50) begin
                if (busy2) n++;
                g++;
                @(negedge clk);
            end
            e = sb2.pop_front();
            total_cnt++;
            if (!done2 || n !== 2) $display("FAIL rand2[%0d] done=%b busy_cycles %0d exp 2", i, done2, n);
            else pass_cnt++;
            total_cnt++;
            if ({res2, bo2, ov2} !== {e.r[1:0], e.bo, e.ov})
                $display("FAIL rand2[%0d] got %h/%b/%b exp %h/%b/%b", i, res2, bo2, ov2, e.r[1:0], e.bo, e.ov);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_random_w32;
        int n, g;
        exp_t e;
        for (int i = 0; i < 1000; i++) begin
            start32 = 1'b1; mode32 = 2'($urandom_range(0, 3)); a32 = $urandom; b32 = $urandom;
            if (i < 4) a32 = (i < 2) ? 32'h8000_0000 : 32'h0;
            sb32.push_back(model(32, mode32, a32, b32));
            @(negedge clk);
            start32 = 1'b0; mode32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
            n = 0; g = 0;
            while (!done32 && g < 100) begin
                if (busy32) n++;
                g++;
                @(negedge clk);
            end
            e = sb32.pop_front();
            total_cnt++;
            if (!done32 || n !== 32) $display("FAIL rand32[%0d] done=%b busy_cycles %0d exp 32", i, done32, n);
            else pass_cnt++;
            total_cnt++;
            if ({res32, bo32, ov32} !== {e.r, e.bo, e.ov})
                $display("FAIL rand32[%0d] got %h/%b/%b exp %h/%b/%b", i, res32, bo32, ov32, e.r, e.bo, e.ov);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_modes;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_run;
        test_random_w2;
        test_random_w32;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
